uart_word_packer: RTL and testbench
===================================

// Module: uart_word_packer
// PURPOSE
// - Sits upstream of the AXI write master on the axi_clk side of the UART-to-DDR path.
// - Packs the synchronised UART byte stream into 256-bit words, byte 0 in [7:0].
// - Buffers complete words in a show-ahead FIFO that drives the master's data_in, check_empty and read_enable.
// - Supports explicit or timeout-driven flush of a partial word, zero-padded.
// PARAMETERS
// - DEPTH           16    word FIFO depth; power of 2, >= 2
// - TIMEOUT_CYCLES  1024  idle cycles before auto-flush (only with PACKER_TIMEOUT_FLUSH_EN)
// PORTS
// - axi_clk      in   1                  clock
// - rst          in   1                  reset, asynchronous, active-low
// - byte_valid   in   1                  byte_data valid
// - byte_data    in   8                  incoming UART byte
// - byte_ready   out  1                  packer accepts byte this cycle
// - flush        in   1                  request push of partial word (pulse or level)
// - data_out     out  256                FIFO head word (to AXI data_in)
// - empty        out  1                  FIFO empty (to AXI check_empty)
// - read_enable  in   1                  pop head word (from AXI read_enable)
// - full         out  1                  FIFO holds DEPTH words
// - level        out  $clog2(DEPTH)+1    words stored
// - underflow    out  1                  sticky: read_enable seen while empty
// BEHAVIOUR
// - Reset, async on rst low:
//   - All FIFO state cleared: level=0, empty=1, full=0, underflow=0, data_out=0.
//   - Pointers cleared, byte_cnt=0, assembly register zeroed, flush_pend=0.
//   - Any partial word is discarded.
// - Byte acceptance:
//   - byte_ready = !(byte_cnt==31 && full). Purely registered-state driven; no comb path from read_enable.
//   - An accepted byte is written to asm[8*byte_cnt +: 8]; byte_cnt increments modulo 32.
// - Word push:
//   - Accepting the byte at byte_cnt==31 writes {byte, asm[247:0]} to the FIFO on the same edge.
//   - Same edge clears asm and sets byte_cnt=0.
//   - Word visible on data_out and empty=0 the next cycle.
// - Flush:
//   - flush=1 sets flush_pend.
//   - While flush_pend, byte_cnt!=0 and !full: push asm zero-padded above the last byte; then asm=0, byte_cnt=0, flush_pend=0.
//   - A byte accepted in the same cycle is merged before the push.
//   - flush_pend with byte_cnt==0 clears with no push.
//   - While full, flush_pend stays set until space frees.
// - Pop:
//   - read_enable && !empty advances rd_ptr; data_out shows the next word combinationally from mem[rd_ptr].
//   - read_enable while empty is ignored and sets underflow. underflow clears only on reset.
// - Simultaneous push+pop: level unchanged. Push+pop while empty: push only (level 0->1).
// - Pointers wrap modulo DEPTH. level range 0..DEPTH; full = (level==DEPTH).
// - A single source drives a push per cycle: complete word has priority; flush is the same push when it merges the byte.
// CONFIGURATION
// - PACKER_TIMEOUT_FLUSH_EN defined:
//   - Idle counter counts cycles with byte_cnt!=0 and no byte accepted.
//   - Counter clears on accept or push.
//   - On reaching TIMEOUT_CYCLES it sets flush_pend internally; flush rules above apply.
// - PACKER_TIMEOUT_FLUSH_EN undefined:
//   - No counter logic.
//   - Partial words leave only on completion or the flush port.
// TESTING
// - Push 32 bytes 0x00..0x1F back-to-back -> 1 cycle later empty=0, level=1, data_out=0x1F1E..0100.
// - Push 5 bytes 0xA1..0xA5, pulse flush -> level=1, data_out[39:0]=0xA5A4A3A2A1, data_out[255:40]=0.
// - Fill DEPTH=16 words, offer 32 more bytes:
//   - byte_ready=0 at byte_cnt==31, full=1.
//   - One read_enable -> byte accepted next cycle, level stays 16.
// - read_enable with empty=1 -> underflow=1, level stays 0; pointers unchanged.
// - Assert rst low after 10 bytes and 3 words -> level=0, empty=1, next 32 bytes form a clean word.
// - With PACKER_TIMEOUT_FLUSH_EN, TIMEOUT_CYCLES=8: 3 bytes then idle -> word pushed after 8 idle cycles.

Source files
------------

// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - packs UART bytes into 256-bit words and queues them in a show-ahead FIFO
// Optional idle-timeout auto-flush enabled by defining PACKER_TIMEOUT_FLUSH_EN.
module uart_word_packer #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       axi_clk,
  input  logic                       rst,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  input  logic                       flush,
  output logic [255:0]               data_out,
  output logic                       empty,
  input  logic                       read_enable,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [255:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic          underflow_q;

  logic [255:0]  asm_word;
  logic [4:0]    byte_cnt;
  logic          flush_pend;
  logic          timeout_hit;

  logic          accept;
  logic          word_push;
  logic          flush_push;
  logic          push;
  logic          pop;
  logic [255:0]  merged_word;

  assign full       = (level_q == (AW+1)'(DEPTH));
  assign empty      = (level_q == '0);
  assign level      = level_q;
  assign underflow  = underflow_q;
  assign data_out   = empty ? '0 : mem[rd_ptr];

  assign byte_ready = !((byte_cnt == 5'd31) && full);
  assign accept     = byte_valid && byte_ready;
  assign word_push  = accept && (byte_cnt == 5'd31);
  assign flush_push = flush_pend && (byte_cnt != 5'd0) && !full;
  assign push       = word_push || flush_push;
  assign pop        = read_enable && !empty;

  // A byte arriving alongside a flush is merged so one push carries both.
  always_comb begin
    merged_word = asm_word;
    if (accept) merged_word[8*byte_cnt +: 8] = byte_data;
  end

  always_ff @(posedge axi_clk or negedge rst) begin
    if (!rst) begin
      asm_word <= '0;
      byte_cnt <= '0;
    end else if (push) begin
      asm_word <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      asm_word <= merged_word;
      byte_cnt <= byte_cnt + 5'd1;
    end
  end

  always_ff @(posedge axi_clk or negedge rst) begin
    if (!rst) flush_pend <= 1'b0;
    else      flush_pend <= (flush_pend && !push && (byte_cnt != 5'd0)) || flush || timeout_hit;
  end

  always_ff @(posedge axi_clk) begin
    if (push) mem[wr_ptr] <= merged_word;
  end

  always_ff @(posedge axi_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level_q <= level_q + (AW+1)'(1);
      else if (pop && !push) level_q <= level_q - (AW+1)'(1);
      if (read_enable && empty) underflow_q <= 1'b1;
    end
  end

`ifdef PACKER_TIMEOUT_FLUSH_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;
  logic          idle_counting;

  assign idle_counting = (byte_cnt != 5'd0) && !accept && !push;
  assign timeout_hit   = idle_counting && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Saturates while the FIFO is full; flush_pend holds the request meanwhile.
  always_ff @(posedge axi_clk or negedge rst) begin
    if (!rst)                                   idle_cnt <= '0;
    else if (!idle_counting)                    idle_cnt <= '0;
    else if (idle_cnt != TW'(TIMEOUT_CYCLES))   idle_cnt <= idle_cnt + TW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_packer.sv
// tb/tb_uart_word_packer.sv - self-checking bench for uart_word_packer against a byte/word queue model
// Define PACKER_TIMEOUT_FLUSH_EN to also exercise the idle-timeout flush.
module tb_uart_word_packer;

  logic         axi_clk = 1'b0;
  logic         rst = 1'b0;
  logic         byte_valid = 1'b0;
  logic [7:0]   byte_data = 8'h00;
  logic         byte_ready;
  logic         flush = 1'b0;
  logic [255:0] data_out;
  logic         empty;
  logic         read_enable = 1'b0;
  logic         full;
  logic [4:0]   level;
  logic         underflow;

  int total = 0;
  int bad   = 0;

  logic [7:0]   part [$];
  logic [255:0] words [$];

  uart_word_packer #(.DEPTH(16), .TIMEOUT_CYCLES(8)) dut (
    .axi_clk(axi_clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .flush(flush), .data_out(data_out), .empty(empty),
    .read_enable(read_enable), .full(full), .level(level), .underflow(underflow)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge axi_clk);
  endtask

  function automatic logic [255:0] pack_part();
    logic [255:0] w = '0;
    foreach (part[i]) w[8*i +: 8] = part[i];
    return w;
  endfunction

  task automatic model_add(input logic [7:0] b);
    part.push_back(b);
    if (part.size() == 32) begin
      words.push_back(pack_part());
      part.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!byte_ready && t < 200) begin
      @(negedge axi_clk);
      t++;
    end
    chk("byte_ready_wait", byte_ready, 1);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge axi_clk);
    byte_valid = 1'b0;
    model_add(b);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge axi_clk);
    flush = 1'b0;
    cyc(3);
    if (part.size() != 0) begin
      words.push_back(pack_part());
      part.delete();
    end
  endtask

  task automatic pop_check(input string tag);
    chk(tag, data_out, words[0]);
    read_enable = 1'b1;
    @(negedge axi_clk);
    read_enable = 1'b0;
    void'(words.pop_front());
  endtask

  task automatic drain(input string tag);
    while (words.size() > 0) pop_check(tag);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_level"}, level, 0);
  endtask

  initial begin
    logic [255:0] exp;
    logic [7:0]   b;
    int           n;

    cyc(3);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ready", byte_ready, 1);
    rst = 1'b1;
    cyc(1);

    read_enable = 1'b1;
    @(negedge axi_clk);
    read_enable = 1'b0;
    chk("uf_flag", underflow, 1);
    chk("uf_level", level, 0);
    chk("uf_empty", empty, 1);

    for (int i = 0; i < 32; i++) send_byte(8'(i));
    exp = '0;
    for (int i = 0; i < 32; i++) exp[8*i +: 8] = 8'(i);
    chk("seq_empty", empty, 0);
    chk("seq_level", level, 1);
    chk("seq_data", data_out, exp);
    drain("seq_pop");

    for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i));
    chk("fl_nopush", level, 0);
    do_flush();
    chk("fl_level", level, 1);
    chk("fl_low", data_out[39:0], 40'hA5A4A3A2A1);
    chk("fl_pad", data_out[255:40], 0);
    drain("fl_pop");

    do_flush();
    chk("fl_idle_level", level, 0);

    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 32; i++) send_byte(8'($urandom));
    n = $urandom_range(1, 31);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
    do_flush();
    chk("rnd_level", level, words.size());
    drain("rnd_pop");

    for (int i = 0; i < 16 * 32 + 31; i++) send_byte(8'($urandom));
    chk("full_flag", full, 1);
    chk("full_level", level, 16);
    chk("full_ready", byte_ready, 0);
    b = 8'($urandom);
    chk("full_head", data_out, words[0]);
    byte_valid  = 1'b1;
    byte_data   = b;
    read_enable = 1'b1;
    @(negedge axi_clk);
    read_enable = 1'b0;
    void'(words.pop_front());
    chk("full_pop_level", level, 15);
    chk("full_pop_ready", byte_ready, 1);
    @(negedge axi_clk);
    byte_valid = 1'b0;
    model_add(b);
    chk("full_refill_level", level, 16);
    chk("full_refill_flag", full, 1);
    drain("full_pop");

    for (int i = 0; i < 3 * 32 + 10; i++) send_byte(8'($urandom));
    chk("pre_rst_level", level, 3);
    #2 rst = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_data", data_out, 0);
    chk("arst_underflow", underflow, 0);
    @(negedge axi_clk);
    rst = 1'b1;
    words.delete();
    part.delete();
    for (int i = 0; i < 32; i++) send_byte(8'($urandom));
    chk("post_rst_level", level, 1);
    drain("post_rst_pop");

`ifdef PACKER_TIMEOUT_FLUSH_EN
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    cyc(5);
    chk("to_early", level, 0);
    cyc(7);
    words.push_back(pack_part());
    part.delete();
    chk("to_level", level, 1);
    drain("to_pop");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
